// File: rtl/sort_pkt_arbiter.sv
// sort_pkt_arbiter: packet-level round-robin arbiter in front of one sorter.
// Ports: clk_i/arst_n_i; snk_* are N_SRC Avalon-ST sinks (data packed
// k*DWIDTH), src_* is the registered stream to the sorter, src_channel_o
// tags each word with its source, pkt_trunc_o pulses with a cut-off word.
module sort_pkt_arbiter #(
  parameter int DWIDTH      = 8,
  parameter int N_SRC       = 4,
  parameter int MAX_PKT_LEN = 256,
  localparam int CW = $clog2(N_SRC),
  localparam int LW = $clog2(MAX_PKT_LEN) + 1
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic [N_SRC*DWIDTH-1:0] snk_data_i,
  input  logic [N_SRC-1:0]        snk_startofpacket_i,
  input  logic [N_SRC-1:0]        snk_endofpacket_i,
  input  logic [N_SRC-1:0]        snk_valid_i,
  output logic [N_SRC-1:0]        snk_ready_o,
  output logic [DWIDTH-1:0]       src_data_o,
  output logic                    src_startofpacket_o,
  output logic                    src_endofpacket_o,
  output logic                    src_valid_o,
  input  logic                    src_ready_i,
  output logic [CW-1:0]           src_channel_o,
  output logic                    pkt_trunc_o
);

  typedef enum logic [1:0] {
    IDLE_S,
    PASS_S,
    DROP_S
  } state_e;

  localparam logic [LW-1:0] LAST = LW'(MAX_PKT_LEN - 1);
  localparam logic [CW-1:0] TOP  = CW'(N_SRC - 1);

  state_e state_q, state_d;

  logic [CW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic              vld_q, vld_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic              trunc_q, trunc_d;

  logic [N_SRC-1:0]  req;
  logic              stage_free;
  logic              accept;

  logic              g_valid;
  logic              g_sop;
  logic              g_eop;
  logic [DWIDTH-1:0] g_data;

  logic [CW-1:0]     pick;
  logic              pick_ok;

  assign req        = snk_valid_i & snk_startofpacket_i;
  assign stage_free = ~vld_q | src_ready_i;

  // Grantee's beat
  always_comb begin
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_data  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant_q == CW'(k)) begin
        g_valid = snk_valid_i[k];
        g_sop   = snk_startofpacket_i[k];
        g_eop   = snk_endofpacket_i[k];
        g_data  = snk_data_i[k*DWIDTH +: DWIDTH];
      end
    end
  end

  // First requester at or above the pointer, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = (int'(ptr_q) + i) % N_SRC;
      if (!pick_ok && req[CW'(idx)]) begin
        pick_ok = 1'b1;
        pick    = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    vld_d       = vld_q;
    data_d      = data_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    chan_d      = chan_q;
    trunc_d     = 1'b0;
    snk_ready_o = '0;
    accept      = 1'b0;

    // A drained stage empties unless a beat reloads it below
    if (stage_free) begin
      vld_d = 1'b0;
    end

    unique case (state_q)
      IDLE_S: begin
        // Stray mid-packet beats are swallowed here
        snk_ready_o = snk_valid_i & ~snk_startofpacket_i;
        if (pick_ok) begin
          grant_d = pick;
          ptr_d   = (pick == TOP) ? '0 : pick + CW'(1);
          len_d   = '0;
          state_d = PASS_S;
        end
      end

      PASS_S: begin
        snk_ready_o[grant_q] = stage_free;
        accept = g_valid & stage_free;
        if (accept) begin
          vld_d  = 1'b1;
          data_d = g_data;
          sop_d  = g_sop;
          eop_d  = g_eop;
          chan_d = grant_q;
          len_d  = len_q + LW'(1);
          if (g_eop) begin
            len_d   = '0;
            state_d = IDLE_S;
          end else if (len_q == LAST) begin
            // Cut the packet so the sorter FIFO cannot overflow
            eop_d   = 1'b1;
            trunc_d = 1'b1;
            len_d   = '0;
            state_d = DROP_S;
          end
        end
      end

      DROP_S: begin
        snk_ready_o[grant_q] = 1'b1;
        if (g_valid && g_eop) begin
          state_d = IDLE_S;
        end
      end

      default: begin
        state_d = IDLE_S;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE_S;
      grant_q <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      chan_q  <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      chan_q  <= chan_d;
      trunc_q <= trunc_d;
    end
  end

  assign src_valid_o         = vld_q;
  assign src_data_o          = data_q;
  assign src_startofpacket_o = sop_q;
  assign src_endofpacket_o   = eop_q;
  assign src_channel_o       = chan_q;
  assign pkt_trunc_o         = trunc_q;

endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// tb_sort_pkt_arbiter: directed and random packets from four sources,
// compared each cycle against a packet-level arbitration model.
module tb_sort_pkt_arbiter;

  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int MAXL = 8;
  localparam int CW   = 2;

  logic            clk_i = 1'b0;
  logic            arst_n_i = 1'b0;
  logic [N*DW-1:0] snk_data_i = '0;
  logic [N-1:0]    snk_startofpacket_i = '0;
  logic [N-1:0]    snk_endofpacket_i = '0;
  logic [N-1:0]    snk_valid_i = '0;
  logic [N-1:0]    snk_ready_o;
  logic [DW-1:0]   src_data_o;
  logic            src_startofpacket_o;
  logic            src_endofpacket_o;
  logic            src_valid_o;
  logic            src_ready_i = 1'b0;
  logic [CW-1:0]   src_channel_o;
  logic            pkt_trunc_o;

  sort_pkt_arbiter #(
    .DWIDTH(DW),
    .N_SRC(N),
    .MAX_PKT_LEN(MAXL)
  ) dut (
    .clk_i(clk_i),
    .arst_n_i(arst_n_i),
    .snk_data_i(snk_data_i),
    .snk_startofpacket_i(snk_startofpacket_i),
    .snk_endofpacket_i(snk_endofpacket_i),
    .snk_valid_i(snk_valid_i),
    .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o),
    .src_startofpacket_o(src_startofpacket_o),
    .src_endofpacket_o(src_endofpacket_o),
    .src_valid_o(src_valid_o),
    .src_ready_i(src_ready_i),
    .src_channel_o(src_channel_o),
    .pkt_trunc_o(pkt_trunc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } beat_t;

  typedef struct {
    int ch;
    int d;
    int s;
    int e;
    int cyc;
  } obs_t;

  beat_t sq[N][$];
  obs_t  olog[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int req_cyc = -1;
  int trunc_cnt = 0;
  int pidx = 0;
  bit rnd_vld = 0;
  int rdy_mode = 0;

  // Packet-level model: who owns the sorter, and the word it holds
  int m_owner;
  bit m_drop;
  int m_ptr;
  int m_cnt;
  bit m_ov, m_os, m_oe, m_tr;
  int m_od, m_och;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_drop  = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_ov    = 0;
    m_os    = 0;
    m_oe    = 0;
    m_tr    = 0;
    m_od    = 0;
    m_och   = 0;
  endtask

  task automatic model_update(input bit free);
    m_tr = 0;
    if (m_owner < 0) begin
      if (free) m_ov = 0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (snk_valid_i[k] && snk_startofpacket_i[k]) begin
          m_owner = k;
          m_ptr   = (k + 1) % N;
          m_cnt   = 0;
          m_drop  = 0;
          break;
        end
      end
    end else if (!m_drop) begin
      if (free) begin
        m_ov = snk_valid_i[m_owner];
        if (m_ov) begin
          m_od  = int'(snk_data_i[m_owner*DW +: DW]);
          m_os  = snk_startofpacket_i[m_owner];
          m_oe  = snk_endofpacket_i[m_owner];
          m_och = m_owner;
          m_cnt++;
          if (m_oe) begin
            m_owner = -1;
          end else if (m_cnt == MAXL) begin
            m_oe   = 1;
            m_tr   = 1;
            m_drop = 1;
          end
        end
      end
    end else begin
      if (free) m_ov = 0;
      if (snk_valid_i[m_owner] && snk_endofpacket_i[m_owner]) begin
        m_owner = -1;
        m_drop  = 0;
      end
    end
  endtask

  task automatic drive();
    beat_t b;
    pidx++;
    for (int k = 0; k < N; k++) begin
      if (sq[k].size() > 0 &&
          (!rnd_vld || $urandom_range(3) != 0)) begin
        b = sq[k][0];
        snk_valid_i[k] = 1'b1;
        snk_data_i[k*DW +: DW] = b.d;
        snk_startofpacket_i[k] = b.s;
        snk_endofpacket_i[k] = b.e;
      end else begin
        snk_valid_i[k] = 1'b0;
        snk_data_i[k*DW +: DW] = DW'($urandom);
        snk_startofpacket_i[k] = 1'b0;
        snk_endofpacket_i[k] = 1'b0;
      end
    end
    case (rdy_mode)
      0: src_ready_i = 1'b1;
      1: src_ready_i = (pidx % 3 == 0);
      default: src_ready_i = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic step();
    logic [N-1:0] acc;
    logic [N-1:0] erdy;
    bit free;
    obs_t o;
    @(negedge clk_i);
    cyc++;
    chk("src_valid", src_valid_o, m_ov);
    if (m_ov) begin
      chk("src_data", src_data_o, m_od);
      chk("src_sop", src_startofpacket_o, m_os);
      chk("src_eop", src_endofpacket_o, m_oe);
      chk("src_channel", src_channel_o, m_och);
    end
    chk("pkt_trunc", pkt_trunc_o, m_tr);
    if (pkt_trunc_o) trunc_cnt++;
    free = !m_ov || src_ready_i;
    erdy = '0;
    if (m_owner < 0) erdy = snk_valid_i & ~snk_startofpacket_i;
    else if (m_drop) erdy[m_owner] = 1'b1;
    else erdy[m_owner] = free;
    chk("snk_ready", snk_ready_o, erdy);
    if (req_cyc < 0 && |(snk_valid_i & snk_startofpacket_i))
      req_cyc = cyc;
    if (src_valid_o && src_ready_i) begin
      o.ch  = int'(src_channel_o);
      o.d   = int'(src_data_o);
      o.s   = int'(src_startofpacket_o);
      o.e   = int'(src_endofpacket_o);
      o.cyc = cyc;
      olog.push_back(o);
    end
    acc = snk_valid_i & snk_ready_o;
    model_update(free);
    @(posedge clk_i);
    #1;
    for (int k = 0; k < N; k++)
      if (acc[k] && sq[k].size() > 0) void'(sq[k].pop_front());
    drive();
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++)
      if (sq[k].size() > 0) return 0;
    return 1;
  endfunction

  task automatic drain(input int budget);
    int n;
    bit done;
    n = 0;
    done = all_empty() && !src_valid_o && m_owner < 0;
    while (!done && n < budget) begin
      step();
      n++;
      done = all_empty() && !src_valid_o && m_owner < 0;
    end
    chk("drain_done", done, 1);
    repeat (2) step();
  endtask

  task automatic push_pkt(input int k, input int len, input int base,
                          input bit rnd);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = rnd ? DW'($urandom) : DW'(base + j);
      b.s = (j == 0);
      b.e = (j == len - 1);
      sq[k].push_back(b);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2;
    arst_n_i = 1'b0;
    #1;
    chk("rst_valid", src_valid_o, 0);
    chk("rst_trunc", pkt_trunc_o, 0);
    for (int k = 0; k < N; k++) sq[k].delete();
    snk_valid_i = '0;
    snk_startofpacket_i = '0;
    snk_endofpacket_i = '0;
    snk_data_i = '0;
    src_ready_i = 1'b0;
    #1;
    chk("rst_ready", snk_ready_o, 0);
    chk("rst_data", src_data_o, 0);
    chk("rst_sop", src_startofpacket_o, 0);
    chk("rst_eop", src_endofpacket_o, 0);
    chk("rst_chan", src_channel_o, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    arst_n_i = 1'b1;
    olog.delete();
    req_cyc = -1;
    trunc_cnt = 0;
    pidx = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    model_reset();

    // 5-word packet from source 0
    do_reset();
    rdy_mode = 0;
    rnd_vld = 0;
    push_pkt(0, 5, 1, 0);
    drain(100);
    chk("t1_count", olog.size(), 5);
    if (olog.size() == 5) begin
      chk("t1_latency", olog[0].cyc - req_cyc, 2);
      for (int i = 0; i < 5; i++) begin
        chk("t1_data", olog[i].d, i + 1);
        chk("t1_chan", olog[i].ch, 0);
        chk("t1_sop", olog[i].s, (i == 0));
        chk("t1_eop", olog[i].e, (i == 4));
        chk("t1_back2back", olog[i].cyc, olog[0].cyc + i);
      end
    end

    // All four request; two rounds of 3-word packets
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push_pkt(k, 3, k*16 + r*8, 0);
    drain(200);
    chk("t2_count", olog.size(), 24);
    if (olog.size() == 24) begin
      for (int p = 0; p < 8; p++)
        for (int j = 0; j < 3; j++) begin
          chk("t2_chan", olog[p*3+j].ch, p % 4);
          chk("t2_data", olog[p*3+j].d, (p%4)*16 + (p/4)*8 + j);
        end
    end

    // Stalling sink on a source-2 packet
    do_reset();
    rdy_mode = 1;
    push_pkt(2, 4, 1, 0);
    drain(100);
    chk("t3_count", olog.size(), 4);
    if (olog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t3_data", olog[i].d, i + 1);
        chk("t3_chan", olog[i].ch, 2);
      end

    // 12-word packet cut to MAXL words
    do_reset();
    rdy_mode = 0;
    push_pkt(1, 12, 1, 0);
    drain(100);
    chk("t4_count", olog.size(), 8);
    chk("t4_trunc_pulses", trunc_cnt, 1);
    if (olog.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk("t4_data", olog[i].d, i + 1);
        chk("t4_eop", olog[i].e, (i == 7));
      end
    push_pkt(1, 2, 40, 0);
    drain(100);
    chk("t4_next_count", olog.size(), 10);
    if (olog.size() == 10) chk("t4_next_sop", olog[8].d, 40);

    // Stray beat while idle
    do_reset();
    begin
      beat_t b;
      b.d = 8'h77;
      b.s = 1'b0;
      b.e = 1'b0;
      sq[3].push_back(b);
    end
    repeat (5) step();
    chk("t5_stray_taken", sq[3].size(), 0);
    chk("t5_stray_out", olog.size(), 0);

    // Reset in the middle of a packet
    push_pkt(2, 6, 1, 0);
    repeat (4) step();
    chk("t6_pre_valid", src_valid_o, 1);
    do_reset();
    push_pkt(3, 2, 100, 0);
    push_pkt(0, 2, 200, 0);
    drain(100);
    chk("t6_count", olog.size(), 4);
    if (olog.size() == 4) begin
      chk("t6_first_chan", olog[0].ch, 0);
      chk("t6_second_chan", olog[2].ch, 3);
    end

    // Random traffic, gaps and backpressure
    do_reset();
    rnd_vld = 1;
    rdy_mode = 2;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(3) == 0) begin
        int k;
        k = $urandom_range(N - 1);
        if (sq[k].size() < 40) begin
          if ($urandom_range(9) == 0) begin
            beat_t b;
            b.d = DW'($urandom);
            b.s = 1'b0;
            b.e = $urandom_range(1);
            sq[k].push_back(b);
          end else begin
            push_pkt(k, $urandom_range(12, 1), 0, 1);
          end
        end
      end
      step();
    end
    drain(4000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
